audio_out: RTL
==============

# audio_out

Downstream consumer of the FM synthesizer's `audio_l`/`audio_r` outputs. Mixes the FM stereo sample with a CPU-fed PCM stream from a 64-entry FIFO, applying a per-source volume with saturation. Serializes the result as a standard I2S stream to the board DAC. Self-timed at clk/512 per stereo frame; the bus-side PCM FIFO decouples CPU writes from the audio rate.

## Interface

Parameters:
- none

Ports:
- `clk` — in, 1: system clock.
- `reset` — in, 1: asynchronous, active-high.
- `bus_addr` — in, 2: register select.
- `bus_wrdata` — in, 32: write data.
- `bus_wren` — in, 1: write strobe, single cycle per access.
- `bus_rddata` — out, 32: combinational read data for `bus_addr`.
- `bus_wait` — out, 1: tied 0; the block never stalls the bus.
- `fm_l`, `fm_r` — in, 16: signed FM samples, held stable between FM sample updates.
- `i2s_bclk` — out, 1: bit clock, clk/8.
- `i2s_lrck` — out, 1: word select; 0 = left, 1 = right.
- `i2s_data` — out, 1: serial data, MSB first.

## Operation

Registers:
- **Addr 0, PCM FIFO**
  - Write pushes `{L[31:16], R[15:0]}`, both signed.
  - Read returns `{16'b0, overflow[15], underflow[14], full[13], empty[12], 5'b0, count[6:0]}`, where count is 0..64.
- **Addr 1, volume**
  - Read/write `{16'b0, fm_vol[15:8], pcm_vol[7:0]}`.
  - Volumes are unsigned; 128 = unity, 255 ≈ 2x.
  - Reset value 0x8080.
- **Addr 2, control**
  - Read `{29'b0, overflow, underflow, pcm_en}`.
  - Write: bit0 sets `pcm_en`; bit1 = 1 clears underflow; bit2 = 1 clears overflow; bit3 = 1 flushes the FIFO (count set to 0).
  - Reset: all 0.
- **Addr 3**: reads 0; writes are ignored.

FIFO:
- 64 x 32 storage.
- Push on write to addr 0 when not full.
- Write when full: data dropped, overflow set (sticky).
- Pop occurs once per frame at the mix point, only if `pcm_en` and not empty.
- Pop needed but FIFO empty (`pcm_en` = 1): PCM contribution is 0 and underflow is set (sticky).
- `pcm_en` = 0: PCM contribution is 0, no pop, no underflow.
- Simultaneous push and pop while full: both occur, count stays 64, no overflow.
- Simultaneous flush and push: flush wins; count ends at 0.

Mix, per channel:
- `t = ($signed(sample) * $signed({1'b0, vol})) >>> 7`, using a 25-bit product and arithmetic shift.
- `sum = t_fm + t_pcm`, sign-extended to 19 bits.
- Saturate to 16 bits: >32767 becomes 0x7FFF; <-32768 becomes 0x8000.

Frame sequencer:
- Counter `cnt[2:0]` runs on every clk.
- Bit counter `b[5:0]` increments when `cnt` == 7 and wraps 63→0.
- Frame slots:
  - b 0..15: left sample bits 15..0.
  - b 16..31: 0.
  - b 32..47: right sample bits 15..0.
  - b 48..63: 0.

## Timing

Reset values:
- `i2s_bclk`, `i2s_lrck`, `i2s_data` = 0.
- `cnt` = 0, `b` = 0.
- FIFO empty, flags 0.
- Output sample registers = 0, so the first frame after reset transmits silence.

I2S signalling:
- `i2s_bclk` = `cnt[2]`: low for cnt 0..3, high for cnt 4..7.
- Data changes on the falling edge (the cycle `cnt` wraps 7→0) and is stable across the rising edge.
- `i2s_lrck` = 1 for b 31..62, 0 otherwise. It therefore changes one BCLK before each channel's MSB (I2S standard).
- `i2s_data` is registered and reflects the current slot `b`.

Mix pipeline:
- Capture: the cycle with `b` == 62 and `cnt` == 7. In that cycle the block captures `fm_l`/`fm_r`, reads the FIFO head and pops it.
- Mixed L/R are registered 1 cycle later.
- Mixed L/R load into the transmit registers on the cycle `b` wraps 63→0.
- Latency from FM capture to left MSB on the pin: 9 clk.
- FM updates between capture points are not used. There is no resampling; the frame period is fixed at 512 clk.

Other:
- Bus writes take effect on the next clk edge. Volume written mid-frame applies from the next capture.
- Reset asserted mid-frame forces all outputs low immediately (asynchronous). After release, the frame restarts at `b` = 0.

## Test plan

- **Reset:** Assert reset mid-frame → all three I2S outputs 0 immediately. After release, first `i2s_lrck` rise after 31×8 clk; first frame all-zero data.
- **FM only:** `fm_l`=0x1234, `fm_r`=0xEDCB, `pcm_en`=0, vol 0x8080 → captured frame shifts 0x1234 on left slot b0..15 and 0xEDCB on right slot b32..47; zeros elsewhere; underflow stays 0.
- **Saturation:** `fm_l`=0x7000, PCM L=0x7000, vol 0x8080 → left 0x7FFF. `fm_r`=0x9000, PCM R=0x9000 → right 0x8000. `fm_vol`=0x40 with `fm_l`=0x1000 and PCM 0 → left 0x0800.
- **FIFO full/overflow:** 65 writes to addr 0 with frames held off → status count=64, full=1, overflow=1. Write 4 to addr 2 → overflow=0.
- **Underflow:** `pcm_en`=1, push 2 words, run 3 frames → frames 1–2 carry PCM, frame 3 PCM=0 with underflow=1, count=0.
- **Push/pop collision:** FIFO full, write to addr 0 on the exact pop cycle (`b`=62, `cnt`=7) → count stays 64, overflow=0, written word appears 64 frames later.

Source files
------------

// File: rtl/audio_out.sv
// Mixes the FM stereo sample with a CPU-fed PCM FIFO stream (per-source volume, saturating)
// and serializes the result as a self-timed I2S stream at clk/512 per stereo frame.
module audio_out (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  bus_addr,
    input  logic [31:0] bus_wrdata,
    input  logic        bus_wren,
    output logic [31:0] bus_rddata,
    output logic        bus_wait,
    input  logic [15:0] fm_l,
    input  logic [15:0] fm_r,
    output logic        i2s_bclk,
    output logic        i2s_lrck,
    output logic        i2s_data
);
    localparam int unsigned DEPTH = 64;
    localparam int unsigned PTR_W = 6;
    localparam int unsigned CNT_W = 7;

    logic [2:0]       cnt_q, cnt_d;
    logic [5:0]       b_q, b_d;
    logic             bclk_q, bclk_d, lrck_q, lrck_d, data_q, data_d;
    logic [15:0]      vol_q, vol_d;
    logic             pcm_en_q, pcm_en_d, ovf_q, ovf_d, unf_q, unf_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      cap_fm_l_q, cap_fm_l_d, cap_fm_r_q, cap_fm_r_d;
    logic [15:0]      cap_pcm_l_q, cap_pcm_l_d, cap_pcm_r_q, cap_pcm_r_d;
    logic [15:0]      cap_vol_q, cap_vol_d;
    logic             mix_en_q, mix_en_d;
    logic [15:0]      mix_l_q, mix_l_d, mix_r_q, mix_r_d;
    logic [15:0]      tx_l_q, tx_l_d, tx_r_q, tx_r_d;
    logic [31:0]      mem_q [DEPTH];

    logic capture_c, wrap_c, fifo_wr_c, ctrl_wr_c, flush_c;
    logic empty_c, full_c, push_c, pop_c;
    logic [31:0] head_c;

    // Scale a signed sample by an unsigned volume where 128 is unity.
    function automatic logic signed [17:0] scale(input logic signed [15:0] s,
                                                 input logic [7:0] v);
        logic signed [24:0] p;
        p = 25'(s) * $signed({17'b0, v});
        return 18'(p >>> 7);
    endfunction

    function automatic logic [15:0] sat(input logic signed [18:0] x);
        if (x > 19'sd32767)
            return 16'h7FFF;
        else if (x < -19'sd32768)
            return 16'h8000;
        else
            return x[15:0];
    endfunction

    always_comb begin
        capture_c = (b_q == 6'd62) && (cnt_q == 3'd7);
        wrap_c    = (b_q == 6'd63) && (cnt_q == 3'd7);
        fifo_wr_c = bus_wren && (bus_addr == 2'd0);
        ctrl_wr_c = bus_wren && (bus_addr == 2'd2);
        flush_c   = ctrl_wr_c && bus_wrdata[3];
        empty_c   = (count_q == CNT_W'(0));
        full_c    = (count_q == CNT_W'(DEPTH));
        pop_c     = capture_c && pcm_en_q && !empty_c;
        push_c    = fifo_wr_c && (!full_c || pop_c);
        head_c    = mem_q[rd_ptr_q];
    end

    // Frame sequencer, FIFO bookkeeping, mix pipeline and I2S output registers.
    always_comb begin
        cnt_d       = cnt_q + 3'd1;
        b_d         = (cnt_q == 3'd7) ? b_q + 6'd1 : b_q;
        vol_d       = vol_q;
        pcm_en_d    = pcm_en_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        cap_fm_l_d  = cap_fm_l_q;
        cap_fm_r_d  = cap_fm_r_q;
        cap_pcm_l_d = cap_pcm_l_q;
        cap_pcm_r_d = cap_pcm_r_q;
        cap_vol_d   = cap_vol_q;
        mix_en_d    = capture_c;
        mix_l_d     = mix_l_q;
        mix_r_d     = mix_r_q;
        tx_l_d      = tx_l_q;
        tx_r_d      = tx_r_q;

        if (bus_wren && (bus_addr == 2'd1))
            vol_d = bus_wrdata[15:0];
        if (ctrl_wr_c) begin
            pcm_en_d = bus_wrdata[0];
            if (bus_wrdata[1]) unf_d = 1'b0;
            if (bus_wrdata[2]) ovf_d = 1'b0;
        end
        if (fifo_wr_c && full_c && !pop_c)
            ovf_d = 1'b1;
        if (capture_c && pcm_en_q && empty_c)
            unf_d = 1'b1;

        if (flush_c) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end

        if (capture_c) begin
            cap_fm_l_d  = fm_l;
            cap_fm_r_d  = fm_r;
            cap_pcm_l_d = pop_c ? head_c[31:16] : 16'h0000;
            cap_pcm_r_d = pop_c ? head_c[15:0]  : 16'h0000;
            cap_vol_d   = vol_q;
        end
        if (mix_en_q) begin
            mix_l_d = sat(19'(scale(cap_fm_l_q, cap_vol_q[15:8])) +
                          19'(scale(cap_pcm_l_q, cap_vol_q[7:0])));
            mix_r_d = sat(19'(scale(cap_fm_r_q, cap_vol_q[15:8])) +
                          19'(scale(cap_pcm_r_q, cap_vol_q[7:0])));
        end
        if (wrap_c) begin
            tx_l_d = mix_l_q;
            tx_r_d = mix_r_q;
        end

        // Outputs track the slot that starts on this edge so data moves on BCLK's falling edge.
        bclk_d = cnt_d[2];
        lrck_d = (b_d >= 6'd31) && (b_d <= 6'd62);
        case (b_d[5:4])
            2'd0:    data_d = tx_l_d[~b_d[3:0]];
            2'd2:    data_d = tx_r_d[~b_d[3:0]];
            default: data_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            b_q         <= '0;
            bclk_q      <= 1'b0;
            lrck_q      <= 1'b0;
            data_q      <= 1'b0;
            vol_q       <= 16'h8080;
            pcm_en_q    <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cap_fm_l_q  <= '0;
            cap_fm_r_q  <= '0;
            cap_pcm_l_q <= '0;
            cap_pcm_r_q <= '0;
            cap_vol_q   <= '0;
            mix_en_q    <= 1'b0;
            mix_l_q     <= '0;
            mix_r_q     <= '0;
            tx_l_q      <= '0;
            tx_r_q      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            b_q         <= b_d;
            bclk_q      <= bclk_d;
            lrck_q      <= lrck_d;
            data_q      <= data_d;
            vol_q       <= vol_d;
            pcm_en_q    <= pcm_en_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cap_fm_l_q  <= cap_fm_l_d;
            cap_fm_r_q  <= cap_fm_r_d;
            cap_pcm_l_q <= cap_pcm_l_d;
            cap_pcm_r_q <= cap_pcm_r_d;
            cap_vol_q   <= cap_vol_d;
            mix_en_q    <= mix_en_d;
            mix_l_q     <= mix_l_d;
            mix_r_q     <= mix_r_d;
            tx_l_q      <= tx_l_d;
            tx_r_q      <= tx_r_d;
        end
    end

    // FIFO storage carries no reset; occupancy lives in count_q.
    always_ff @(posedge clk) begin
        if (push_c)
            mem_q[wr_ptr_q] <= bus_wrdata;
    end

    always_comb begin
        bus_rddata = 32'h0;
        case (bus_addr)
            2'd0:    bus_rddata = {16'h0, ovf_q, unf_q, full_c, empty_c, 5'b0, count_q};
            2'd1:    bus_rddata = {16'h0, vol_q};
            2'd2:    bus_rddata = {29'h0, ovf_q, unf_q, pcm_en_q};
            default: bus_rddata = 32'h0;
        endcase
    end

    assign bus_wait = 1'b0;
    assign i2s_bclk = bclk_q;
    assign i2s_lrck = lrck_q;
    assign i2s_data = data_q;
endmodule
